instr_fetch_buf: RTL and testbench
==================================

Name: instr_fetch_buf

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute path and replaces its direct combinational instruction-memory read. It issues word fetches to a variable-latency instruction memory over a req/gnt/rvalid handshake. Returned words are buffered with their PC in a small FIFO and presented to the core with a valid/ready handshake. A core redirect (taken branch or jal) flushes the buffer and restarts fetch at the target PC.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  fetch request; held until mem_gnt
mem_addr  output  32  word-aligned fetch address; stable while mem_req=1
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  response data valid; at most one per grant, earliest the cycle after gnt
mem_rdata  input  32  fetched instruction word
instr_valid  output  1  head FIFO entry valid
instr  output  32  head instruction; 32'h00000013 (NOP) when instr_valid=0
instr_pc  output  32  PC of head instruction; 0 when instr_valid=0
instr_ready  input  1  core consumes head entry this cycle
redirect  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0
fifo_count  output  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, kill=0, count=0.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=NOP, instr_pc=0.
- FSM states: IDLE, REQ, WAIT, DROP. mem_req = (state==REQ).
- IDLE:
  - If redirect=0 and count<DEPTH: go to REQ and set req_addr<=fetch_pc.
  - mem_rvalid is ignored in IDLE, so stale responses after reset are discarded.
- REQ:
  - On mem_gnt: go to WAIT if kill=0 and redirect=0, otherwise go to DROP.
  - On a gnt that is not killed, fetch_pc<=fetch_pc+4 (wraps modulo 2^32).
  - On redirect with no gnt: mem_req stays asserted, mem_addr is unchanged, and kill<=1.
  - kill clears on leaving REQ.
- WAIT:
  - On mem_rvalid: push {fetch-address, mem_rdata} into the FIFO, then go to IDLE.
  - If redirect is also asserted in that cycle, the push is discarded.
  - On redirect without mem_rvalid: go to DROP.
- DROP: on mem_rvalid, discard the data and go to IDLE.
- Redirect in any state: fetch_pc<=redirect_pc, FIFO count<=0. Redirect takes priority over the gnt-increment, push and pop.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Push to a full FIFO cannot occur, because IDLE->REQ requires count<DEPTH and only one request is outstanding.
- Latency with gnt in the REQ cycle and rvalid one cycle later:
  - mem_req is asserted in cycle 1 after reset release.
  - instr_valid is asserted in cycle 3.
  - Steady-state throughput is 1 instruction per 3 cycles.
- Only one request is outstanding at any time.

Optional Feature:
FETCH_PERF_EN:
- When defined, adds two outputs:
  - perf_drop_cnt[15:0]: responses discarded in DROP, or discarded in WAIT due to redirect.
  - perf_stall_cnt[15:0]: cycles with instr_ready=1 and instr_valid=0.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent and the block behaves otherwise identically.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, DROP)
  - INSTR_NOP=32'h00000013
  - FETCH_STEP=32'd4
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head output.
  - flush has priority over push and pop.

Test Plan:
- Reset release; memory grants immediately and responds next cycle with 32'h00300093 at 0x0 → mem_addr=0x0 in cycle 1; instr_valid=1 with instr=32'h00300093 and instr_pc=0 in cycle 3; next mem_addr=0x4.
- Hold instr_ready=0 for 20 cycles → exactly 4 fetches (0x0–0xC); fifo_count=4; mem_req stays 0. Assert instr_ready → entries drain in order; fetch of 0x10 resumes.
- Redirect to 0x40 while in WAIT; then mem_rvalid arrives → response discarded; fifo_count=0; next mem_addr=0x40; first valid instr_pc=0x40.
- Redirect to 0x80 while mem_req=1 and gnt withheld 3 cycles → mem_addr stays at old value until gnt; response dropped; next request mem_addr=0x80.
- Redirect coincident with a pop and an rvalid → count=0 and the response is not pushed; instr_valid=0 next cycle; instr=32'h00000013.
- Reset asserted in WAIT, then a stale rvalid after release → ignored; first mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP  = 32'h00000013;
  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of fetched {pc, instr}; flush beats push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset; the head is only meaningful while count is nonzero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_buf.sv
// rtl/instr_fetch_buf.sv - req/gnt/rvalid instruction fetcher feeding a valid/ready FIFO
// Optional perf counters are built when FETCH_PERF_EN is defined.
module instr_fetch_buf
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]              perf_drop_cnt,
  output logic [15:0]              perf_stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_req_addr;
  logic [31:0]   w_req_addr_nxt;
  logic          r_kill;
  logic          w_kill_nxt;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_kill_nxt     = r_kill;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!redirect && (w_count < FULL_COUNT)) begin
          w_next_state   = REQ;
          w_req_addr_nxt = r_fetch_pc;
        end
      end
      REQ: begin
        // The request cannot be withdrawn once raised, so a redirect only marks it dead.
        if (mem_gnt) begin
          w_kill_nxt = 1'b0;
          if (!r_kill && !redirect) begin
            w_next_state   = WAIT;
            w_fetch_pc_nxt = r_fetch_pc + FETCH_STEP;
          end else begin
            w_next_state = DROP;
          end
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_next_state = IDLE;
          w_push       = ~redirect;
        end else if (redirect) begin
          w_next_state = DROP;
        end
      end
      DROP: begin
        if (mem_rvalid) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (redirect) w_fetch_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
  end

  assign w_entry = {r_req_addr, mem_rdata};
  assign w_pop   = instr_valid & instr_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_req     = (r_state == REQ);
  assign mem_addr    = r_req_addr;
  assign instr_valid = (w_count != '0);
  assign instr       = instr_valid ? w_head.instr : INSTR_NOP;
  assign instr_pc    = instr_valid ? w_head.pc : 32'h0;
  assign fifo_count  = w_count;

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_drop;
  logic [15:0] r_perf_stall;
  logic        w_drop_rsp;
  logic        w_stall;

  assign w_drop_rsp = mem_rvalid & ((r_state == DROP) | ((r_state == WAIT) & redirect));
  assign w_stall    = instr_ready & ~instr_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_drop_rsp && (r_perf_drop != 16'hFFFF))  r_perf_drop  <= r_perf_drop + 16'd1;
      if (w_stall && (r_perf_stall != 16'hFFFF))    r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_drop_cnt  = r_perf_drop;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_buf.sv
// tb/tb_instr_fetch_buf.sv - directed bench with a queue-based model of the fetch stream
module tb_instr_fetch_buf;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_gnt = 1'b0;
  logic                   mem_rvalid = 1'b0;
  logic [31:0]            mem_rdata = '0;
  logic                   instr_valid;
  logic [31:0]            instr;
  logic [31:0]            instr_pc;
  logic                   instr_ready = 1'b0;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = '0;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef FETCH_PERF_EN
  logic [15:0]            perf_drop_cnt;
  logic [15:0]            perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_buf #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_EN
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fifo_count     (fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00300093 : {a[23:0], 8'h13};
  endfunction

  // memory responder knobs/state
  int          gnt_hold = 0;
  int          rv_delay = 1;
  int          req_age  = 0;
  int          rv_cnt   = 0;
  logic        rv_pend  = 1'b0;
  logic [31:0] rv_addr  = '0;
  logic        gnt_now  = 1'b0;

  // model: expected buffer contents and fetch bookkeeping
  fetch_entry_t q[$];
  logic [31:0]  exp_pc  = RESET_PC;
  logic [31:0]  out_pc  = '0;
  logic         live    = 1'b0;
  logic         any_out = 1'b0;
  logic         tainted = 1'b0;

  // Drive memory for the coming edge, advance the model by that edge, then compare.
  task automatic tick();
    fetch_entry_t e;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    gnt_now    = 1'b0;
    if (rv_pend) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(rv_addr);
        rv_pend    = 1'b0;
      end
    end
    if (mem_req && reset) begin
      if (req_age >= gnt_hold) begin
        mem_gnt = 1'b1;
        gnt_now = 1'b1;
        rv_pend = 1'b1;
        rv_cnt  = rv_delay;
        rv_addr = mem_addr;
        req_age = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end

    if (!reset) begin
      q.delete();
      exp_pc  = RESET_PC;
      live    = 1'b0;
      any_out = 1'b0;
      tainted = 1'b0;
    end else begin
      chk("single_outstanding", {31'b0, mem_req && any_out}, 32'd0);
      if (q.size() == DEPTH) chk("no_req_when_full", {31'b0, mem_req}, 32'd0);
      if ((q.size() != 0) && instr_ready) void'(q.pop_front());
      if (mem_rvalid) begin
        if (live && !redirect) begin
          e.pc    = out_pc;
          e.instr = mem_rdata;
          q.push_back(e);
        end
        live    = 1'b0;
        any_out = 1'b0;
      end
      if (mem_req && mem_gnt) begin
        if (!tainted && !redirect) begin
          chk("gnt_addr", mem_addr, exp_pc);
          live   = 1'b1;
          out_pc = exp_pc;
          exp_pc = exp_pc + 32'd4;
        end else begin
          live = 1'b0;
        end
        any_out = 1'b1;
        tainted = 1'b0;
      end else if (mem_req && redirect) begin
        tainted = 1'b1;
      end
      if (redirect) begin
        q.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        live   = 1'b0;
      end
    end

    @(negedge clk);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("instr", instr, (q.size() != 0) ? q[0].instr : INSTR_NOP);
    chk("instr_pc", instr_pc, (q.size() != 0) ? q[0].pc : 32'h0);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!mem_req && k < 30) begin tick(); k++; end
    chk(name, {31'b0, mem_req}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid && k < 30) begin tick(); k++; end
    chk(name, {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic wait_gnt(input string name);
    int k = 0;
    gnt_now = 1'b0;
    while (!gnt_now && k < 30) begin tick(); k++; end
    chk(name, {31'b0, gnt_now}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h00000013);
    chk({tag, "_pc"}, instr_pc, 32'h0);
  endtask

  logic [31:0] old_addr;

  initial begin
    repeat (3) tick();
    chk_reset_state("reset");
    chk("reset_count", 32'(fifo_count), 32'd0);

    // first fetch latency
    reset = 1'b1;
    tick();
    chk("c1_req", {31'b0, mem_req}, 32'd1);
    chk("c1_addr", mem_addr, 32'h0);
    tick();
    tick();
    chk("c3_valid", {31'b0, instr_valid}, 32'd1);
    chk("c3_instr", instr, 32'h00300093);
    chk("c3_pc", instr_pc, 32'h0);
    tick();
    chk("c4_req", {31'b0, mem_req}, 32'd1);
    chk("c4_addr", mem_addr, 32'h4);

    // back-pressure fills the buffer, then drains in order
    repeat (20) tick();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_no_req", {31'b0, mem_req}, 32'd0);
    chk("full_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    chk("drain_head", instr_pc, 32'h4);
    tick();
    chk("drain_head2", instr_pc, 32'h8);
    wait_req("resume_req");
    chk("resume_addr", mem_addr, 32'h10);
    repeat (6) tick();

    // redirect while waiting for data
    rv_delay = 3;
    wait_gnt("wait_gnt1");
    redirect    = 1'b1;
    redirect_pc = 32'h41;
    tick();
    redirect = 1'b0;
    rv_delay = 1;
    chk("rw_count", 32'(fifo_count), 32'd0);
    wait_req("rw_req");
    chk("rw_addr", mem_addr, 32'h40);
    wait_valid("rw_valid");
    chk("rw_pc", instr_pc, 32'h40);

    // redirect while the request is held without grant
    gnt_hold = 3;
    wait_req("rq_req");
    old_addr    = mem_addr;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect = 1'b0;
      chk("rq_held_req", {31'b0, mem_req}, 32'd1);
      chk("rq_held_addr", mem_addr, old_addr);
    end
    tick();
    chk("rq_drop", {31'b0, mem_req}, 32'd0);
    gnt_hold = 0;
    wait_req("rq_req2");
    chk("rq_addr", mem_addr, 32'h80);
    wait_valid("rq_valid");
    chk("rq_pc", instr_pc, 32'h80);

    // redirect coincident with pop and response
    instr_ready = 1'b0;
    wait_valid("co_fill");
    wait_gnt("co_gnt");
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("co_valid", {31'b0, instr_valid}, 32'd0);
    chk("co_instr", instr, 32'h00000013);
    chk("co_count", 32'(fifo_count), 32'd0);
    wait_valid("co_valid2");
    chk("co_pc", instr_pc, 32'h100);
    repeat (4) tick();

    // reset during WAIT, stale response after release
    rv_delay = 2;
    wait_gnt("rs_gnt");
    reset = 1'b0;
    tick();
    chk_reset_state("rs");
    reset = 1'b1;
    tick();
    rv_delay = 1;
    chk("rs_req", {31'b0, mem_req}, 32'd1);
    chk("rs_addr", mem_addr, RESET_PC);
    wait_valid("rs_valid");
    chk("rs_pc", instr_pc, 32'h0);
    chk("rs_instr", instr, 32'h00300093);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
